// File: rtl/pc_unit.sv
// pc_unit: registered program counter for the BIP core.
// It advances by STEP or redirects on branch, jump, call or return.
// A small return-address stack serves call/return, and the unit reports halt and stack-error status.
module pc_unit #(
    parameter int unsigned LEN_ADDR    = 11,
    parameter int unsigned STEP        = 1,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [2:0]          op,
    input  logic [LEN_ADDR-1:0] target,
    input  logic [LEN_ADDR-1:0] offset,
    output logic [LEN_ADDR-1:0] pc,
    output logic                halted,
    output logic                stack_empty,
    output logic                stack_full,
    output logic                stack_err
);

    // Depth counter must represent 0..STACK_DEPTH; the stack index only 0..STACK_DEPTH-1.
    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_SEQ    = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;
    localparam logic [2:0] OP_HALT   = 3'b101;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [LEN_ADDR-1:0] pc_q, pc_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic                err_q, err_d;
    logic [LEN_ADDR-1:0] stack_q [STACK_DEPTH];

    logic                push_en;
    logic [IW-1:0]       push_idx;
    logic [IW-1:0]       top_idx;
    logic [LEN_ADDR-1:0] seq_pc;
    logic                full_c;
    logic                empty_c;

    assign seq_pc   = pc_q + LEN_ADDR'(STEP);
    assign full_c   = (depth_q == DW'(STACK_DEPTH));
    assign empty_c  = (depth_q == '0);
    assign push_idx = IW'(depth_q);
    assign top_idx  = IW'(depth_q - DW'(1));

    // Next-state decode: one op consumed per enabled cycle while running.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        err_d   = err_q;
        push_en = 1'b0;
        if ((state_q == ST_RUN) && enable) begin
            case (op)
                OP_BRANCH: pc_d = pc_q + offset;
                OP_JUMP:   pc_d = target;
                OP_CALL: begin
                    if (!full_c) begin
                        push_en = 1'b1;
                        pc_d    = target;
                        depth_d = depth_q + DW'(1);
                    end else begin
                        pc_d  = seq_pc;
                        err_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!empty_c) begin
                        pc_d    = stack_q[top_idx];
                        depth_d = depth_q - DW'(1);
                    end else begin
                        pc_d  = seq_pc;
                        err_d = 1'b1;
                    end
                end
                OP_HALT:   state_d = ST_HALT;
                OP_SEQ:    pc_d = seq_pc;
                default:   pc_d = seq_pc;
            endcase
        end
    end

    // Control state, pc, depth and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= LEN_ADDR'(RESET_ADDR);
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage; contents are don't-care after reset, so it has no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= seq_pc;
        end
    end

    assign pc          = pc_q;
    assign halted      = (state_q == ST_HALT);
    assign stack_empty = empty_c;
    assign stack_full  = full_c;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit.
// An independent behavioural model pushes the expected outputs as each op is driven.
// Each scenario task pops an entry after the edge and compares it with the DUT.
module tb_pc_unit;

    localparam logic [2:0] SEQ = 3'd0, BRA = 3'd1, JMP = 3'd2, CAL = 3'd3,
                           RET = 3'd4, HLT = 3'd5;

    typedef struct packed {
        logic [10:0] pc;
        logic        halted;
        logic        empty;
        logic        full;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [10:0] target = '0;
    logic [10:0] offset = '0;
    logic [10:0] pc;
    logic        halted, stack_empty, stack_full, stack_err;
    exp_t        obs;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    logic [10:0] m_pc;
    logic        m_err, m_halt;
    logic [10:0] m_stack [$];
    exp_t        sb [$];

    pc_unit #(.LEN_ADDR(11), .STEP(1), .STACK_DEPTH(4), .RESET_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .op(op),
        .target(target), .offset(offset), .pc(pc), .halted(halted),
        .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    assign obs = '{pc: pc, halted: halted, empty: stack_empty, full: stack_full, err: stack_err};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model_out();
        exp_t e;
        e.pc     = m_pc;
        e.halted = m_halt;
        e.empty  = (m_stack.size() == 0);
        e.full   = (m_stack.size() == 4);
        e.err    = m_err;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = '0; m_err = 1'b0; m_halt = 1'b0;
        m_stack.delete();
        sb.delete();
    endtask

    task automatic model_step(input logic [2:0] o, input logic [10:0] t, input logic [10:0] f,
                              input logic e);
        logic [10:0] nxt;
        nxt = m_pc + 11'd1;
        if (e && !m_halt) begin
            case (o)
                BRA: m_pc = m_pc + f;
                JMP: m_pc = t;
                CAL: if (m_stack.size() == 4) begin m_pc = nxt; m_err = 1'b1; end
                     else begin m_stack.push_back(nxt); m_pc = t; end
                RET: if (m_stack.size() == 0) begin m_pc = nxt; m_err = 1'b1; end
                     else m_pc = m_stack.pop_back();
                HLT: m_halt = 1'b1;
                default: m_pc = nxt;
            endcase
        end
    endtask

    // Drive one op after an edge, push its expectation, advance to just after the next edge.
    task automatic drive(input logic [2:0] o, input logic [10:0] t, input logic [10:0] f,
                         input logic e);
        op = o; target = t; offset = f; enable = e;
        model_step(o, t, f, e);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        enable = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        apply_reset();
        e = '{pc: 11'd0, halted: 1'b0, empty: 1'b1, full: 1'b0, err: 1'b0};
        n_tests++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_state got %h exp %h", obs, e);
        end
    endtask

    task automatic test_seq_enable();
        exp_t e;
        logic [10:0] want [5] = '{11'd1, 11'd2, 11'd3, 11'd3, 11'd3};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(SEQ, 11'd0, 11'd0, (i < 3));
            e = sb.pop_front();
            n_tests++;
            if (obs !== e || pc !== want[i]) begin
                n_fail++;
                $display("FAIL seq_enable[%0d] got %h pc %0d exp %h pc %0d", i, obs, pc, e, want[i]);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [10:0] want [2] = '{11'd2047, 11'd0};
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive((i == 0) ? JMP : SEQ, 11'd2047, 11'd0, 1'b1);
            e = sb.pop_front();
            n_tests++;
            if (obs !== e || pc !== want[i] || stack_err !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap[%0d] got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        logic [2:0]  ops  [3] = '{JMP, BRA, BRA};
        logic [10:0] offs [3] = '{11'd0, 11'h7FD, 11'd5};
        logic [10:0] want [3] = '{11'd10, 11'd7, 11'd12};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], 11'd10, offs[i], 1'b1);
            e = sb.pop_front();
            n_tests++;
            if (obs !== e || pc !== want[i]) begin
                n_fail++;
                $display("FAIL branch[%0d] got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_nested_call();
        exp_t e;
        logic [2:0]  ops  [5] = '{JMP, CAL, CAL, RET, RET};
        logic [10:0] tgts [5] = '{11'd5, 11'd100, 11'd200, 11'd0, 11'd0};
        logic [10:0] want [5] = '{11'd5, 11'd100, 11'd200, 11'd101, 11'd6};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], tgts[i], 11'd0, 1'b1);
            e = sb.pop_front();
            n_tests++;
            if (obs !== e || pc !== want[i]) begin
                n_fail++;
                $display("FAIL nested_call[%0d] got %h exp %h", i, obs, e);
            end
        end
        n_tests++;
        if (stack_empty !== 1'b1 || stack_err !== 1'b0) begin
            n_fail++;
            $display("FAIL nested_final got empty=%b err=%b exp empty=1 err=0", stack_empty, stack_err);
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(CAL, 11'(10 * (i + 1)), 11'd0, 1'b1);
            e = sb.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL overflow[%0d] got %h exp %h", i, obs, e);
            end
        end
        n_tests++;
        if (pc !== 11'd41 || stack_full !== 1'b1 || stack_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_final got pc=%0d full=%b err=%b exp pc=41 full=1 err=1",
                     pc, stack_full, stack_err);
        end
        apply_reset();
        drive(RET, 11'd0, 11'd0, 1'b1);
        e = sb.pop_front();
        n_tests++;
        if (obs !== e || pc !== 11'd1 || stack_err !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow got %h exp %h", obs, e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [2:0] ops [8] = '{CAL, RET, CAL, CAL, RET, CAL, RET, RET};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(ops[i], 11'(300 + 16 * i), 11'd0, 1'b1);
            e = sb.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [2:0] o;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            do o = 3'($urandom_range(0, 7)); while (o == HLT);
            drive(o, 11'($urandom), 11'($urandom), ($urandom_range(0, 3) != 0));
            e = sb.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d got %h exp %h", i, o, obs, e);
            end
        end
    endtask

    task automatic test_halt();
        exp_t e;
        logic [2:0] ops [5] = '{JMP, HLT, JMP, JMP, JMP};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], (i == 0) ? 11'd9 : 11'd500, 11'd0, 1'b1);
            e = sb.pop_front();
            n_tests++;
            if (obs !== e || pc !== 11'd9 || halted !== (i > 0)) begin
                n_fail++;
                $display("FAIL halt[%0d] got %h exp %h", i, obs, e);
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (pc !== 11'd0 || halted !== 1'b0 || stack_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset got pc=%0d halted=%b exp pc=0 halted=0", pc, halted);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(SEQ, 11'd0, 11'd0, 1'b1);
        e = sb.pop_front();
        n_tests++;
        if (obs !== e || pc !== 11'd1) begin
            n_fail++;
            $display("FAIL post_reset_seq got %h exp %h", obs, e);
        end
    endtask

    initial begin
        test_reset();
        test_seq_enable();
        test_wrap();
        test_branch();
        test_nested_call();
        test_overflow();
        test_back_to_back();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
